cic_interp_mr: RTL and testbench

//  Multi-rate CIC interpolator: successor of the fixed-rate CIC, feeding the sigma-delta modulator at clk rate.

---
 rtl/cic_interp_mr.sv | 155 +++++++++++++++
 tb/tb_cic_interp_mr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_mr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cic_interp_mr : multi-rate CIC interpolator with valid/ready input, runtime |
// | rate/shift, sync clear and underrun flag. Optional: CIC_MR_SAT_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cic_interp_mr #(
  parameter int IN_WIDTH   = 4,
  parameter int OUT_WIDTH  = 4,
  parameter int STAGES     = 3,
  parameter int MAX_RATE   = 16,
  parameter int DIFF_DELAY = 1,
  parameter int ACC_W      = IN_WIDTH + STAGES * $clog2(MAX_RATE * DIFF_DELAY),
  parameter int RATE_W     = $clog2(MAX_RATE + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clr,
  input  logic [RATE_W-1:0]           rate,
  input  logic [5:0]                  out_shift,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        underrun
);

  localparam int                  c_cnt_w    = $clog2(STAGES + 3);
  localparam logic [c_cnt_w-1:0]  c_prime    = c_cnt_w'(STAGES + 2);
  localparam logic [RATE_W-1:0]   c_rate_min = RATE_W'(2);
  localparam logic [RATE_W-1:0]   c_rate_max = RATE_W'(MAX_RATE);

  logic [RATE_W-1:0]           r_phase;
  logic [RATE_W-1:0]           r_rate_q;
  logic [RATE_W-1:0]           w_rate_clamp;
  logic                        w_phase0;
  logic                        w_wrap;
  logic                        w_xfer;
  logic signed [ACC_W-1:0]     r_comb_dly [STAGES][DIFF_DELAY];
  logic signed [ACC_W-1:0]     w_comb [STAGES+1];
  logic signed [ACC_W-1:0]     r_stuff;
  logic signed [ACC_W-1:0]     r_integ [STAGES];
  logic signed [ACC_W-1:0]     w_shifted;
  logic signed [OUT_WIDTH-1:0] w_out_next;
  logic [c_cnt_w-1:0]          r_prime_cnt;
  logic                        r_valid;

  always_comb begin
    w_rate_clamp = rate;
    if (rate < c_rate_min)
      w_rate_clamp = c_rate_min;
    else if (rate > c_rate_max)
      w_rate_clamp = c_rate_max;
  end

  assign w_phase0  = (r_phase == '0);
  assign w_wrap    = (r_phase == r_rate_q - RATE_W'(1));
  // rst_n gates the combinational outputs so they read 0 while reset is held.
  assign in_ready  = rst_n & enable & ~clr & w_phase0;
  assign underrun  = in_ready & ~in_valid;
  assign w_xfer    = in_ready & in_valid;
  assign out_valid = r_valid & enable;

  assign w_comb[0] = w_xfer ? ACC_W'(in_data) : '0;

  for (genvar i = 0; i < STAGES; i++) begin : g_comb
    assign w_comb[i+1] = w_comb[i] - r_comb_dly[i][DIFF_DELAY-1];
  end

  assign w_shifted = r_integ[STAGES-1] >>> out_shift;

`ifdef CIC_MR_SAT_EN
  localparam int c_ext_w = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic signed [c_ext_w-1:0] c_out_max =
    c_ext_w'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [c_ext_w-1:0] c_out_min = ~c_out_max;

  logic signed [c_ext_w-1:0] w_shift_ext;
  assign w_shift_ext = c_ext_w'(w_shifted);

  always_comb begin
    w_out_next = OUT_WIDTH'(w_shift_ext);
    if (w_shift_ext > c_out_max)
      w_out_next = OUT_WIDTH'(c_out_max);
    else if (w_shift_ext < c_out_min)
      w_out_next = OUT_WIDTH'(c_out_min);
  end
`else
  assign w_out_next = OUT_WIDTH'(w_shifted);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= '0;
      r_rate_q    <= c_rate_max;
      r_stuff     <= '0;
      out_data    <= '0;
      r_prime_cnt <= '0;
      r_valid     <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_integ[i] <= '0;
        for (int k = 0; k < DIFF_DELAY; k++)
          r_comb_dly[i][k] <= '0;
      end
    end else if (clr) begin
      r_phase     <= '0;
      r_rate_q    <= w_rate_clamp;
      r_stuff     <= '0;
      out_data    <= '0;
      r_prime_cnt <= '0;
      r_valid     <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_integ[i] <= '0;
        for (int k = 0; k < DIFF_DELAY; k++)
          r_comb_dly[i][k] <= '0;
      end
    end else if (enable) begin
      // Rate only reloads at frame end so a frame is never cut short.
      if (w_wrap) begin
        r_phase  <= '0;
        r_rate_q <= w_rate_clamp;
      end else begin
        r_phase <= r_phase + RATE_W'(1);
      end

      if (w_phase0) begin
        r_stuff <= w_comb[STAGES];
        for (int i = 0; i < STAGES; i++) begin
          r_comb_dly[i][0] <= w_comb[i];
          for (int k = 1; k < DIFF_DELAY; k++)
            r_comb_dly[i][k] <= r_comb_dly[i][k-1];
        end
      end else begin
        r_stuff <= '0;
      end

      r_integ[0] <= r_integ[0] + r_stuff;
      for (int i = 1; i < STAGES; i++)
        r_integ[i] <= r_integ[i] + r_integ[i-1];

      out_data <= w_out_next;

      if (r_prime_cnt != c_prime)
        r_prime_cnt <= r_prime_cnt + c_cnt_w'(1);
      r_valid <= (r_prime_cnt >= c_prime - c_cnt_w'(1));
    end else begin
      r_prime_cnt <= '0;
      r_valid     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_mr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cic_interp_mr : directed self-checking bench for cic_interp_mr           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cic_interp_mr;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              clr;
  logic [4:0]        rate;
  logic [5:0]        out_shift;
  logic signed [3:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] out_data;
  logic              out_valid;
  logic              underrun;

  int n_tests = 0;
  int n_fail  = 0;

  cic_interp_mr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clr       (clr),
    .rate      (rate),
    .out_shift (out_shift),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, counting in_ready and underrun assertions at mid-cycle.
  task automatic run(input int n, output int rdy, output int und);
    rdy = 0;
    und = 0;
    repeat (n) begin
      @(negedge clk);
      rdy += int'(in_ready);
      und += int'(underrun);
      cyc();
    end
  endtask

  // Returns in the cycle just after a phase-0 cycle.
  task automatic wait_ready(input string tag, input int max_cyc);
    int  n    = 0;
    logic seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      seen = in_ready;
      cyc();
      n++;
    end
    check_val(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rdy, und, bad, min_out;

    rst_n     = 1'b0;
    enable    = 1'b1;
    clr       = 1'b0;
    rate      = 5'd8;
    out_shift = 6'd0;
    in_data   = 4'sd0;
    in_valid  = 1'b1;

    #2;
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_underrun", underrun, 0);

    cyc();
    cyc();
    rst_n = 1'b1;

    // First frame runs at the reset rate of 16, then rate 8 takes over.
    run(4, rdy, und);
    check_val("first_frame_rdy_a", rdy, 1);
    @(negedge clk); check_val("prime_4_cycles", out_valid, 0); cyc();
    @(negedge clk); check_val("prime_5_cycles", out_valid, 1); cyc();
    run(10, rdy, und);
    check_val("first_frame_rdy_b", rdy, 0);
    @(negedge clk); check_val("second_frame_start", in_ready, 1); cyc();

    // Impulse latency at shift 0: transfer at cycle 24, output at 29.
    in_data = 4'sd1;
    run(7, rdy, und);
    @(negedge clk); check_val("impulse_xfer", in_ready, 1); cyc();
    in_data = 4'sd0;
    cyc(); cyc(); cyc();
    @(negedge clk); check_val("latency_t_plus_4", out_data, 0); cyc();
    @(negedge clk); check_val("latency_t_plus_5", out_data, 1); cyc();

    // Unity-gain step at R=8, shift 6.
    out_shift = 6'd6;
    in_data   = 4'sd1;
    run(64, rdy, und);
    check_val("step_rdy_per_64", rdy, 8);
    check_val("step_underrun", und, 0);
    @(negedge clk); check_val("step_plus1", out_data, 1); cyc();
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_data !== 4'sd1) bad++;
      cyc();
    end
    check_val("step_hold_bad", bad, 0);

    in_data = -4'sd8;
    run(64, rdy, und);
    @(negedge clk); check_val("step_minus8", out_data, -8); cyc();

    // Missing sample at phase 0.
    in_data = 4'sd4;
    run(64, rdy, und);
    @(negedge clk); check_val("dc_4", out_data, 4); cyc();
    wait_ready("underrun_align", 20);
    in_valid = 1'b0;
    run(8, rdy, und);
    check_val("underrun_pulse", und, 1);
    check_val("underrun_ready", rdy, 1);
    in_valid = 1'b1;
    min_out = 100;
    und = 0;
    repeat (40) begin
      @(negedge clk);
      if (int'(out_data) < min_out) min_out = int'(out_data);
      und += int'(underrun);
      cyc();
    end
    check_val("underrun_dip", (min_out < 4) ? 1 : 0, 1);
    check_val("underrun_none_after", und, 0);
    run(40, rdy, und);
    @(negedge clk); check_val("underrun_recover", out_data, 4); cyc();

    // 7 * 64 >> 5 = 14: saturates to 7 or wraps to -2.
    out_shift = 6'd5;
    in_data   = 4'sd7;
    run(64, rdy, und);
`ifdef CIC_MR_SAT_EN
    @(negedge clk); check_val("sat_out", out_data, 7); cyc();
`else
    @(negedge clk); check_val("wrap_out", out_data, -2); cyc();
`endif

    // Rate switch 8 -> 4 requested at phase 3.
    out_shift = 6'd6;
    in_data   = 4'sd0;
    run(64, rdy, und);
    @(negedge clk); check_val("dc_0", out_data, 0); cyc();
    wait_ready("switch_align", 20);
    run(2, rdy, und);
    rate = 5'd4;
    run(5, rdy, und);
    check_val("switch_no_truncate", rdy, 0);
    @(negedge clk); check_val("switch_wrap", in_ready, 1); cyc();
    run(32, rdy, und);
    check_val("rate4_rdy_per_32", rdy, 8);
    out_shift = 6'd4;
    in_data   = 4'sd5;
    run(64, rdy, und);
    check_val("rate4_underrun", und, 0);
    @(negedge clk); check_val("rate4_dc_5", out_data, 5); cyc();

    // Clamping at both ends.
    rate = 5'd1;
    run(8, rdy, und);
    run(16, rdy, und);
    check_val("clamp_low_rdy", rdy, 8);
    rate = 5'd20;
    run(8, rdy, und);
    run(64, rdy, und);
    check_val("clamp_high_rdy", rdy, 4);

    // Synchronous clear loads rate 8 at once.
    rate = 5'd8;
    clr  = 1'b1;
    @(negedge clk); check_val("clr_in_ready", in_ready, 0); cyc();
    clr = 1'b0;
    rdy = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rdy += int'(in_ready);
      if (i == 0) check_val("clr_out_data", out_data, 0);
      if (i < 5 && out_valid !== 1'b0) bad++;
      if (i == 5) check_val("clr_valid_back", out_valid, 1);
      cyc();
    end
    check_val("clr_valid_low_bad", bad, 0);
    check_val("clr_rdy_per_16", rdy, 2);

    // Freeze with enable low.
    out_shift = 6'd6;
    run(64, rdy, und);
    @(negedge clk); check_val("pre_freeze_5", out_data, 5); cyc();
    enable  = 1'b0;
    in_data = -4'sd3;
    run(10, rdy, und);
    check_val("freeze_rdy", rdy, 0);
    check_val("freeze_underrun", und, 0);
    @(negedge clk);
    check_val("freeze_out_valid", out_valid, 0);
    check_val("freeze_hold", out_data, 5);
    cyc();
    enable = 1'b1;
    @(negedge clk); check_val("enable_rise_valid", out_valid, 0); cyc();
    run(20, rdy, und);

    // Asynchronous reset mid-cycle.
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_data", out_data, 0);
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_in_ready", in_ready, 0);
    check_val("mid_rst_underrun", underrun, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk); check_val("post_rst_phase0", in_ready, 1); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
